// File: rtl/usart_pkg.sv
// Shared usart definitions: rx FSM encoding, default link parameters, width helper.
package usart_pkg;

    localparam int unsigned USART_CLKS_PER_BIT = 8;
    localparam int unsigned USART_DATA_BITS    = 8;
    localparam int unsigned USART_FIFO_DEPTH   = 4;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Smallest n such that 2**n >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/usart_sync_fifo.sv
// Synchronous FIFO with registered read data; a pop on a full FIFO frees the slot
// for a push in the same cycle, a pop on an empty FIFO is ignored.
module usart_sync_fifo
    import usart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    // Accept/ignore decisions, storage update and next pointer/count values.
    always_comb begin
        pop_ok_c  = pop && (count_q != '0);
        push_ok_c = push && ((count_q != DEPTH_CNT) || pop_ok_c);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rdata_d   = rdata_q;
        count_d   = count_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rdata_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
    end

    // Pointer, count, status and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = rdata_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: rtl/usart_rx_core.sv
// 8N1 LSB-first serial receiver: resynchronises the line, validates the start bit
// mid-bit, samples data mid-bit, checks the stop bit and buffers bytes in a FIFO.
module usart_rx_core
    import usart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = USART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = USART_DATA_BITS,
    parameter int unsigned FIFO_DEPTH   = USART_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial_in,
    input  logic                 rx_read_en,
    input  logic                 rx_clear_err,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_empty,
    output logic                 rx_full,
    output logic                 rx_overrun,
    output logic                 rx_frame_err
);

    localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rxs_c;
    logic                 cnt_zero_c;
    logic                 push_c;
    logic                 overrun_set_c;
    logic                 frame_set_c;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign rxs_c      = sync2_q;
    assign cnt_zero_c = (cnt_q == '0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every decision uses the resynchronised line.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:      if (!rxs_c) state_d = RX_START;
            RX_START:     if (cnt_zero_c) state_d = rxs_c ? RX_IDLE : RX_DATA;
            RX_DATA:      if (cnt_zero_c && (bit_q == LAST_BIT)) state_d = RX_STOP;
            RX_STOP:      if (cnt_zero_c) state_d = rxs_c ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rxs_c) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // Counters, shift register, push/error strobes and sticky flags.
    always_comb begin
        sync1_d       = rx_serial_in;
        sync2_d       = sync1_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push_c        = 1'b0;
        overrun_set_c = 1'b0;
        frame_set_c   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxs_c) cnt_d = HALF_LOAD;
            end
            RX_START: begin
                if (cnt_zero_c) begin
                    cnt_d = FULL_LOAD;
                    bit_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_zero_c) begin
                    shift_d[bit_q] = rxs_c;
                    cnt_d          = FULL_LOAD;
                    bit_d          = (bit_q == LAST_BIT) ? '0 : bit_q + BIT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_zero_c) begin
                    if (rxs_c) begin
                        // A pop in the same cycle frees a slot in a full FIFO.
                        if (!fifo_full || rx_read_en) push_c = 1'b1;
                        else overrun_set_c = 1'b1;
                    end else begin
                        frame_set_c = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
        // Set beats clear when both happen in one cycle.
        overrun_d   = overrun_set_c ? 1'b1 : (rx_clear_err ? 1'b0 : overrun_q);
        frame_err_d = frame_set_c   ? 1'b1 : (rx_clear_err ? 1'b0 : frame_err_q);
    end

    // Synchroniser, datapath and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    usart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shift_q),
        .pop       (rx_read_en),
        .pop_data  (rx_data_out),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rx_empty     = fifo_empty;
    assign rx_full      = fifo_full;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_usart_rx_core.sv
// Directed bench for usart_rx_core with CLKS_PER_BIT=4.
module tb_usart_rx_core;

    localparam int unsigned C = 4;

    logic       clk;
    logic       rst;
    logic       rx_serial_in;
    logic       rx_read_en;
    logic       rx_clear_err;
    logic [7:0] rx_data_out;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_overrun;
    logic       rx_frame_err;

    int errors;
    int checks;

    usart_rx_core #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_serial_in (rx_serial_in),
        .rx_read_en   (rx_read_en),
        .rx_clear_err (rx_clear_err),
        .rx_data_out  (rx_data_out),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit plus data bits, LSB first; leaves the line at the last data bit.
    task automatic send_head(input logic [7:0] d);
        rx_serial_in = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx_serial_in = d[i];
            tick(C);
        end
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d);
        rx_serial_in = 1'b1;
        tick(C);
    endtask

    task automatic pop_byte();
        rx_read_en = 1'b1;
        tick(1);
        rx_read_en = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        rx_serial_in = 1'b1;
        rx_read_en   = 1'b0;
        rx_clear_err = 1'b0;
        tick(3);
        check("rst_data", 32'(rx_data_out), 32'h00);
        check("rst_empty", 32'(rx_empty), 32'h1);
        check("rst_full", 32'(rx_full), 32'h0);
        check("rst_overrun", 32'(rx_overrun), 32'h0);
        check("rst_frame_err", 32'(rx_frame_err), 32'h0);
        rst = 1'b1;
        tick(2);

        // 1: back-to-back frames, exact push latency, in-order pops
        send_frame(8'hA5);
        check("t1_empty_before_push", 32'(rx_empty), 32'h1);
        send_frame(8'h3C);
        check("t1_empty_after_push", 32'(rx_empty), 32'h0);
        send_frame(8'hF0);
        send_frame(8'h99);
        tick(2);
        check("t1_full", 32'(rx_full), 32'h1);
        pop_byte(); check("t1_pop0", 32'(rx_data_out), 32'hA5);
        pop_byte(); check("t1_pop1", 32'(rx_data_out), 32'h3C);
        pop_byte(); check("t1_pop2", 32'(rx_data_out), 32'hF0);
        pop_byte(); check("t1_pop3", 32'(rx_data_out), 32'h99);
        check("t1_empty", 32'(rx_empty), 32'h1);
        check("t1_overrun", 32'(rx_overrun), 32'h0);
        check("t1_frame_err", 32'(rx_frame_err), 32'h0);

        // 2: overrun on a 5th frame into a full FIFO
        send_frame(8'h01);
        check("t2_latency_before", 32'(rx_empty), 32'h1);
        tick(1);
        check("t2_latency_edge", 32'(rx_empty), 32'h0);
        send_frame(8'h02);
        send_frame(8'h03);
        send_frame(8'h04);
        tick(2);
        check("t2_full", 32'(rx_full), 32'h1);
        check("t2_no_overrun_yet", 32'(rx_overrun), 32'h0);
        send_frame(8'h05);
        tick(2);
        check("t2_overrun", 32'(rx_overrun), 32'h1);
        pop_byte(); check("t2_pop0", 32'(rx_data_out), 32'h01);
        pop_byte(); check("t2_pop1", 32'(rx_data_out), 32'h02);
        pop_byte(); check("t2_pop2", 32'(rx_data_out), 32'h03);
        pop_byte(); check("t2_pop3", 32'(rx_data_out), 32'h04);
        check("t2_empty", 32'(rx_empty), 32'h1);
        rx_clear_err = 1'b1;
        tick(1);
        rx_clear_err = 1'b0;
        check("t2_overrun_cleared", 32'(rx_overrun), 32'h0);

        // 3: held break after 0x55 gives one frame error, then 0x66 is received
        send_head(8'h55);
        rx_serial_in = 1'b0;
        tick(3 * C);
        check("t3_frame_err", 32'(rx_frame_err), 32'h1);
        check("t3_no_push", 32'(rx_empty), 32'h1);
        rx_clear_err = 1'b1;
        tick(1);
        rx_clear_err = 1'b0;
        check("t3_cleared_in_break", 32'(rx_frame_err), 32'h0);
        rx_serial_in = 1'b1;
        tick(2 * C);
        check("t3_single_error", 32'(rx_frame_err), 32'h0);
        send_frame(8'h66);
        tick(2);
        check("t3_empty_after_66", 32'(rx_empty), 32'h0);
        pop_byte(); check("t3_pop", 32'(rx_data_out), 32'h66);
        check("t3_only_one", 32'(rx_empty), 32'h1);

        // 4: one-cycle glitch is rejected, receiver still works afterwards
        rx_serial_in = 1'b0;
        tick(1);
        rx_serial_in = 1'b1;
        tick(3 * C);
        check("t4_empty", 32'(rx_empty), 32'h1);
        check("t4_overrun", 32'(rx_overrun), 32'h0);
        check("t4_frame_err", 32'(rx_frame_err), 32'h0);
        send_frame(8'h5A);
        tick(2);
        pop_byte(); check("t4_recover", 32'(rx_data_out), 32'h5A);

        // 5: pop coincident with the stop sample of a 5th frame into a full FIFO
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        send_frame(8'h44);
        tick(2);
        check("t5_full", 32'(rx_full), 32'h1);
        send_head(8'h7E);
        rx_serial_in = 1'b1;
        tick(C);
        rx_read_en = 1'b1;
        tick(1);
        rx_read_en = 1'b0;
        check("t5_pop_at_stop", 32'(rx_data_out), 32'h11);
        check("t5_still_full", 32'(rx_full), 32'h1);
        check("t5_no_overrun", 32'(rx_overrun), 32'h0);
        pop_byte(); check("t5_pop1", 32'(rx_data_out), 32'h22);
        pop_byte(); check("t5_pop2", 32'(rx_data_out), 32'h33);
        pop_byte(); check("t5_pop3", 32'(rx_data_out), 32'h44);
        pop_byte(); check("t5_pop4", 32'(rx_data_out), 32'h7E);
        check("t5_empty", 32'(rx_empty), 32'h1);

        // 6: reset mid-frame with a flag set and a byte buffered
        send_head(8'h00);
        rx_serial_in = 1'b0;
        tick(C);
        rx_serial_in = 1'b1;
        tick(C);
        check("t6_pre_frame_err", 32'(rx_frame_err), 32'h1);
        send_frame(8'hAA);
        tick(2);
        check("t6_pre_empty", 32'(rx_empty), 32'h0);
        rx_serial_in = 1'b0;
        tick(C);
        rx_serial_in = 1'b1;
        tick(C);
        rx_serial_in = 1'b0;
        tick(2);
        rst          = 1'b0;
        rx_serial_in = 1'b1;
        tick(2);
        check("t6_rst_data", 32'(rx_data_out), 32'h00);
        check("t6_rst_empty", 32'(rx_empty), 32'h1);
        check("t6_rst_full", 32'(rx_full), 32'h0);
        check("t6_rst_overrun", 32'(rx_overrun), 32'h0);
        check("t6_rst_frame_err", 32'(rx_frame_err), 32'h0);
        rst = 1'b1;
        tick(2 * C);
        check("t6_abandoned", 32'(rx_empty), 32'h1);
        send_frame(8'hC3);
        tick(2);
        check("t6_empty_after_c3", 32'(rx_empty), 32'h0);
        pop_byte(); check("t6_pop", 32'(rx_data_out), 32'hC3);
        check("t6_empty", 32'(rx_empty), 32'h1);
        pop_byte(); check("t6_pop_empty_data", 32'(rx_data_out), 32'hC3);
        check("t6_pop_empty_flag", 32'(rx_empty), 32'h1);
        check("t6_frame_err_end", 32'(rx_frame_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
